copro_exec_scheduler: RTL

COPRO_EXEC_SCHEDULER -- requirements
Module: copro_exec_scheduler

---
 rtl/copro_exec_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/copro_exec_scheduler.sv
// Purpose: in-order offload queue; holds each op until it is committed, then runs the head op on the execution unit and returns writeback results.
// Latency: a committed op entering an empty queue starts one cycle later; result_valid_o rises one cycle after exe_done_i.
// Backpressure: in_ready_o drops while the queue is full; the result is held stable and no new op starts until result_ready_i.
module copro_exec_scheduler #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned NrRgprPorts = 2,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned OpcodeWidth = 4,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned HartidWidth = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [OpcodeWidth-1:0]      in_opcode_i,
    input  logic [IdWidth-1:0]          in_id_i,
    input  logic [HartidWidth-1:0]      in_hartid_i,
    input  logic [4:0]                  in_rd_i,
    input  logic                        in_writeback_i,
    input  logic [NrRgprPorts*XLEN-1:0] in_rs_i,
    input  logic                        commit_valid_i,
    input  logic [IdWidth-1:0]          commit_id_i,
    input  logic                        commit_kill_i,
    output logic                        exe_start_o,
    output logic [OpcodeWidth-1:0]      exe_opcode_o,
    output logic [NrRgprPorts*XLEN-1:0] exe_rs_o,
    input  logic                        exe_done_i,
    input  logic [XLEN-1:0]             exe_result_i,
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [IdWidth-1:0]          result_id_o,
    output logic [HartidWidth-1:0]      result_hartid_o,
    output logic [4:0]                  result_rd_o,
    output logic [XLEN-1:0]             result_data_o,
    output logic [$clog2(Depth+1)-1:0]  occupancy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth+1);
    localparam int unsigned RsW  = NrRgprPorts*XLEN;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    typedef struct packed {
        logic [OpcodeWidth-1:0] opcode;
        logic [IdWidth-1:0]     id;
        logic [HartidWidth-1:0] hartid;
        logic [4:0]             rd;
        logic                   writeback;
        logic [RsW-1:0]         rs;
    } entry_t;

    entry_t          mem_q [Depth];
    logic [Depth-1:0] vld_q;
    logic [Depth-1:0] cmt_q;
    logic [Depth-1:0] kill_q;
    logic [Depth-1:0] hit;
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;
    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic [XLEN-1:0] res_data_q;

    entry_t head;
    entry_t in_entry;
    logic   empty;
    logic   push;
    logic   pop;
    logic   start;
    logic   capture;
    logic   in_hit;

    assign head     = mem_q[head_q];
    assign empty    = (count_q == '0);
    assign push     = in_valid_i && in_ready_o;
    assign in_hit   = commit_valid_i && (in_id_i == commit_id_i);
    assign in_entry = '{opcode: in_opcode_i, id: in_id_i, hartid: in_hartid_i,
                        rd: in_rd_i, writeback: in_writeback_i, rs: in_rs_i};

    // Commit lookup: which resident entries carry the id being committed
    always_comb begin
        hit = '0;
        for (int i = 0; i < Depth; i++) begin
            hit[i] = commit_valid_i && vld_q[i] && (mem_q[i].id == commit_id_i);
        end
    end

    // Sequencer: wait for commit, drop killed ops, launch, then hand back the result
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        start   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE, WAIT: begin
                if (empty) begin
                    state_d = IDLE;
                end else if (!cmt_q[head_q]) begin
                    state_d = WAIT;
                end else if (kill_q[head_q]) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else begin
                    start   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (exe_done_i) begin
                    capture = 1'b1;
                    if (head.writeback) begin
                        state_d = RESP;
                    end else begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue bookkeeping: per-slot flags, pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            cmt_q   <= '0;
            kill_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < Depth; i++) begin
                if (hit[i]) begin
                    cmt_q[i] <= 1'b1;
                    if (commit_kill_i) kill_q[i] <= 1'b1;
                end
            end
            // The tail slot is never valid on a push, so it cannot collide with the hit loop
            if (push) begin
                vld_q[tail_q]  <= 1'b1;
                cmt_q[tail_q]  <= in_hit;
                kill_q[tail_q] <= in_hit && commit_kill_i;
                tail_q         <= tail_q + PtrW'(1);
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Payload storage; slot contents only matter while the slot is valid
    always_ff @(posedge clk_i) begin
        if (push) mem_q[tail_q] <= in_entry;
    end

    // Sequencer state and captured result
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            res_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) res_data_q <= exe_result_i;
        end
    end

    assign in_ready_o      = (count_q != CntW'(Depth));
    assign occupancy_o     = count_q;
    assign exe_start_o     = start;
    assign exe_opcode_o    = empty ? '0 : head.opcode;
    assign exe_rs_o        = empty ? '0 : head.rs;
    assign result_valid_o  = (state_q == RESP);
    assign result_id_o     = result_valid_o ? head.id : '0;
    assign result_hartid_o = result_valid_o ? head.hartid : '0;
    assign result_rd_o     = result_valid_o ? head.rd : '0;
    assign result_data_o   = result_valid_o ? res_data_q : '0;

endmodule
